rx_byte_packer_256: RTL and testbench
=====================================

// Module: rx_byte_packer_256
// PURPOSE
//  Upstream stage of the 256-bit RX FIFO. Packs the RX MAC byte stream into 32-byte words and drives the FIFO write port.
//  Each frame starts on a fresh word; a trailing partial word is zero-padded.
//  Per-frame status (length, good/bad) goes out on a side channel.
//  Absorbs one word of FIFO backpressure; beyond that the frame is dropped and flagged bad.
// PARAMETERS
//  DATA_W     256   FIFO word width in bits; must be a multiple of 8 (BYTES = DATA_W/8 = 32)
//  LEN_W      16    width of frame_len
//  MAX_BYTES  1536  longest legal frame in bytes; longer frames are bad
// PORTS
//  clk         in   1        system clock, all logic on posedge
//  reset       in   1        asynchronous, active-low reset
//  rx_data     in   8        received byte
//  rx_valid    in   1        rx_data valid this cycle (gaps allowed)
//  rx_sof      in   1        first byte of frame (qualified by rx_valid)
//  rx_eof      in   1        last byte of frame (qualified by rx_valid; may coincide with rx_sof)
//  rx_err      in   1        MAC error on this byte (qualified by rx_valid)
//  fifo_din    out  DATA_W   packed word; byte k in bits [8k+7:8k], byte 0 = earliest
//  fifo_write  out  1        = pend_valid & ~fifo_full (combinational)
//  fifo_full   in   1        FIFO full flag
//  frame_done  out  1        1-cycle pulse: frame finished, status valid
//  frame_len   out  LEN_W    byte count of finished frame, saturating at 2^LEN_W-1
//  frame_bad   out  1        finished frame had an error, overflow, oversize or missing eof
//  overflow    out  1        sticky; set on any dropped word, cleared only by reset
// BEHAVIOUR
//  Reset (reset=0, async):
//   - state=IDLE; byte index, length, pend_valid, all outputs and accumulator = 0
//  State machine IDLE / RECV / DROP:
//   - IDLE: bytes without rx_sof are ignored. rx_valid&rx_sof stores byte 0, len=1, -> RECV (or completes at once if rx_eof).
//   - RECV: each valid byte goes into lane idx; idx and len increment.
//   - Word complete (idx==31 accepted or eof): the accumulator, zero-padded above the last byte, moves to pend at the next edge.
//     pend_valid=1 the cycle after the byte; idx resets to 0.
//   - Pend drains when fifo_write=1. pend_valid clears on that edge unless a new word loads the same edge.
//   - Overflow: a word completes while pend_valid=1 and fifo_full=1.
//     -> word discarded, overflow=1, frame marked bad, -> DROP (or IDLE if that byte had rx_eof).
//   - DROP: discard bytes until rx_eof, keep counting len, then frame_done with frame_bad=1 -> IDLE.
//  Frame end:
//   - frame_done pulses the cycle after the eof byte, with frame_len = total bytes received.
//   - frame_bad = any rx_err | overflow | len>MAX_BYTES.
//   - Words already written are not retracted; downstream discards by frame_bad.
//   - eof exactly on idx==31: exactly one word pushed, no empty trailing word.
//  rx_sof while in RECV/DROP (missing eof):
//   - flush the partial word if any (padded), pulse frame_done with frame_bad=1 for the old frame.
//   - the same byte starts a new frame at idx 0.
//  Oversize: len>MAX_BYTES -> frame marked bad; packing continues until eof.
//  fifo_din stays stable while pend_valid & fifo_full (holds until accepted).
//  Throughput: one byte per cycle sustained; at most one word write per cycle.
// TESTING
//  1. 64-byte frame, data 0x00..0x3F back-to-back, fifo_full=0 -> 2 writes.
//     word0 bytes 0x00..0x1F, word1 0x20..0x3F; frame_len=64, frame_bad=0.
//  2. 33-byte frame -> 2 writes; word1 = 0x00...0020 (byte0=0x20, rest 0); frame_len=33.
//  3. fifo_full=1 held through a 96-byte frame.
//     -> word0 held on fifo_din; word1 dropped; overflow=1; frame_done with frame_bad=1, frame_len=96.
//  4. 32-byte frame with rx_valid gaps every other cycle -> exactly 1 write, no padded extra word, frame_bad=0.
//  5. Frame A sof + 10 bytes, then sof of frame B (no eof).
//     -> A: padded word pushed, frame_done with frame_bad=1, frame_len=10; B packs from lane 0.
//  6. reset low mid-frame (byte 20) -> outputs 0 immediately.
//     After release, bytes without sof are ignored; the next sof frame packs cleanly.

Source files
------------

// File: rtl/rx_byte_packer_256_if.sv
// Signal bundle around the RX byte packer: MAC byte stream in, FIFO write port
// and per-frame status out. The master modport is the packer's own view.
interface rx_byte_packer_256_if #(
  parameter int DATA_W = 256,
  parameter int LEN_W  = 16
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_sof;
  logic              rx_eof;
  logic              rx_err;
  logic [DATA_W-1:0] fifo_din;
  logic              fifo_write;
  logic              fifo_full;
  logic              frame_done;
  logic [LEN_W-1:0]  frame_len;
  logic              frame_bad;
  logic              overflow;

  modport master (
    input  rx_data, rx_valid, rx_sof, rx_eof, rx_err, fifo_full,
    output fifo_din, fifo_write, frame_done, frame_len, frame_bad, overflow
  );

  modport slave (
    output rx_data, rx_valid, rx_sof, rx_eof, rx_err, fifo_full,
    input  fifo_din, fifo_write, frame_done, frame_len, frame_bad, overflow
  );
endinterface

// File: rtl/rx_byte_packer_256.sv
// Packs the RX MAC byte stream into DATA_W-bit FIFO words, one frame per fresh word,
// with a single-word pend buffer for backpressure and a per-frame status side channel.
module rx_byte_packer_256 #(
  parameter int DATA_W    = 256,
  parameter int LEN_W     = 16,
  parameter int MAX_BYTES = 1536
) (
  input  logic                 clk,
  input  logic                 reset,
  rx_byte_packer_256_if.master bus
);
  localparam int               BYTES   = DATA_W / 8;
  localparam int               IDX_W   = $clog2(BYTES);
  localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};
  localparam int unsigned      MAX_U   = MAX_BYTES;

  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

  state_t            state, state_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [LEN_W-1:0]  len, len_n, len_inc;
  logic [DATA_W-1:0] acc, acc_n, pend, pend_n;
  logic [DATA_W-1:0] lane0_word, word, push_word;
  logic              bad, bad_n, bad_now;
  logic              pend_valid, pend_valid_n;
  logic              overflow, overflow_n;
  logic              done, done_n;
  logic [LEN_W-1:0]  flen, flen_n;
  logic              fbad, fbad_n;
  logic              blocked, push;

  // A completing word can only be stored if pend is empty or drains on this same edge.
  assign blocked    = pend_valid & bus.fifo_full;
  assign lane0_word = DATA_W'(bus.rx_data);
  assign word       = acc | (lane0_word << {idx, 3'b000});
  assign len_inc    = (len == LEN_MAX) ? len : len + LEN_W'(1);

  always_comb begin
    // NOTE: every target gets a default first so no path through the decode infers a latch.
    state_n      = state;
    idx_n        = idx;
    len_n        = len;
    acc_n        = acc;
    bad_n        = bad;
    bad_now      = bad;
    pend_n       = pend;
    pend_valid_n = blocked;
    overflow_n   = overflow;
    done_n       = 1'b0;
    flen_n       = flen;
    fbad_n       = fbad;
    push         = 1'b0;
    push_word    = word;

    if (bus.rx_valid) begin
      if (bus.rx_sof) begin
        // A sof inside a frame closes the old one as bad; a sof+eof byte here opens a
        // normal multi-byte frame, since one cycle cannot report two frame ends.
        if (state != IDLE) begin
          done_n    = 1'b1;
          flen_n    = len;
          fbad_n    = 1'b1;
          push      = (state == RECV) && (idx != '0);
          push_word = acc;
        end
        acc_n   = lane0_word;
        idx_n   = IDX_W'(1);
        len_n   = LEN_W'(1);
        bad_n   = bus.rx_err;
        state_n = RECV;
        if (bus.rx_eof && state == IDLE) begin
          push      = 1'b1;
          push_word = lane0_word;
          acc_n     = '0;
          idx_n     = '0;
          bad_n     = 1'b0;
          state_n   = IDLE;
          done_n    = 1'b1;
          flen_n    = LEN_W'(1);
          fbad_n    = bus.rx_err | blocked;
        end
      end else if (state != IDLE) begin
        len_n = len_inc;
        if (state == RECV) begin
          bad_now = bad | bus.rx_err | (32'(len_inc) > MAX_U);
          if (idx == IDX_W'(BYTES - 1) || bus.rx_eof) begin
            push  = 1'b1;
            acc_n = '0;
            idx_n = '0;
            if (blocked) begin
              bad_now = 1'b1;
              state_n = DROP;
            end
          end else begin
            acc_n = word;
            idx_n = idx + IDX_W'(1);
          end
          bad_n = bad_now;
        end
        if (bus.rx_eof) begin
          done_n  = 1'b1;
          flen_n  = len_inc;
          fbad_n  = bad_now;
          state_n = IDLE;
        end
      end
    end

    if (push) begin
      if (blocked) begin
        overflow_n = 1'b1;
      end else begin
        pend_n       = push_word;
        pend_valid_n = 1'b1;
      end
    end
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      idx        <= '0;
      len        <= '0;
      bad        <= 1'b0;
      // NOTE: the wide accumulator and pend word are reset too, so fifo_din reads zero out of reset.
      acc        <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
      overflow   <= 1'b0;
      done       <= 1'b0;
      flen       <= '0;
      fbad       <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      len        <= len_n;
      bad        <= bad_n;
      acc        <= acc_n;
      pend       <= pend_n;
      pend_valid <= pend_valid_n;
      overflow   <= overflow_n;
      done       <= done_n;
      flen       <= flen_n;
      fbad       <= fbad_n;
    end
  end

  assign bus.fifo_din   = pend;
  assign bus.fifo_write = pend_valid & ~bus.fifo_full;
  assign bus.frame_done = done;
  assign bus.frame_len  = flen;
  assign bus.frame_bad  = fbad;
  assign bus.overflow   = overflow;
endmodule

// File: tb/tb_rx_byte_packer_256.sv
// Randomized scoreboard bench for rx_byte_packer_256: frames are modelled as byte lists
// chunked into words, with a one-slot buffer occupancy model for backpressure.
module tb_rx_byte_packer_256;
  localparam int DATA_W    = 256;
  localparam int LEN_W     = 16;
  localparam int MAX_BYTES = 1536;
  localparam int BYTES     = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;
  typedef struct packed {
    logic [LEN_W-1:0] len;
    logic             bad;
  } status_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rx_byte_packer_256_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  rx_byte_packer_256 #(.DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BYTES(MAX_BYTES)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  word_t        exp_words[$];
  status_t      exp_stat[$];
  status_t      mon_s;
  byte unsigned cur[$];
  bit           in_frame, dropping, m_occ, m_ovf, m_bad;
  int           m_len;
  byte unsigned fb[$];
  bit           fe[$];

  task automatic check(input string name, input word_t act, input word_t exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic word_t pack(input byte unsigned q[$]);
    word_t w = '0;
    foreach (q[i]) w[8*i +: 8] = q[i];
    return w;
  endfunction

  function automatic status_t mk_status(input int len, input bit b);
    status_t s;
    s.len = LEN_W'(len);
    s.bad = b;
    return s;
  endfunction

  function automatic bit pick_full(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic model_reset();
    cur.delete();
    exp_words.delete();
    exp_stat.delete();
    in_frame = 0; dropping = 0; m_occ = 0; m_ovf = 0; m_bad = 0; m_len = 0;
  endtask

  // Reference behaviour for the upcoming clock edge, given the inputs applied for it.
  task automatic model_step(input bit v, input byte unsigned d, input bit s, input bit e,
                            input bit er, input bit full);
    bit blocked = m_occ && full;
    bit occ_n   = m_occ && full;
    bit was     = in_frame;
    if (v) begin
      if (s) begin
        if (was) begin
          if (!dropping && cur.size() != 0) begin
            if (blocked) m_ovf = 1;
            else begin exp_words.push_back(pack(cur)); occ_n = 1; end
          end
          exp_stat.push_back(mk_status(m_len, 1'b1));
        end
        cur = {d}; m_len = 1; m_bad = er; in_frame = 1; dropping = 0;
        if (e && !was) begin
          if (blocked) begin m_ovf = 1; m_bad = 1; end
          else begin exp_words.push_back(pack(cur)); occ_n = 1; end
          exp_stat.push_back(mk_status(1, m_bad));
          cur.delete();
          in_frame = 0;
        end
      end else if (in_frame) begin
        m_len = (m_len < 65535) ? m_len + 1 : m_len;
        m_bad = m_bad | er | (m_len > MAX_BYTES);
        if (!dropping) begin
          cur.push_back(d);
          if (cur.size() == BYTES || e) begin
            if (blocked) begin m_ovf = 1; m_bad = 1; dropping = 1; end
            else begin exp_words.push_back(pack(cur)); occ_n = 1; end
            cur.delete();
          end
        end
        if (e) begin
          exp_stat.push_back(mk_status(m_len, m_bad));
          in_frame = 0;
          dropping = 0;
        end
      end
    end
    m_occ = occ_n;
  endtask

  task automatic drive(input bit v, input byte unsigned d, input bit s, input bit e,
                       input bit er, input bit full);
    @(posedge clk);
    #1;
    bus.rx_valid  = v;
    bus.rx_data   = d;
    bus.rx_sof    = s;
    bus.rx_eof    = e;
    bus.rx_err    = er;
    bus.fifo_full = full;
    model_step(v, d, s, e, er, full);
  endtask

  task automatic idle(input bit full);
    drive(1'b0, 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), full);
  endtask

  // gap: 0 none, 1 every other cycle, 2 random; full_mode: 0 never, 1 always, 2 random
  task automatic send_frame(input bit with_eof, input int gap, input int full_mode);
    for (int i = 0; i < fb.size(); i++) begin
      if (gap == 1 && i != 0) idle(pick_full(full_mode));
      if (gap == 2) while ($urandom_range(0, 9) < 3) idle(pick_full(full_mode));
      drive(1'b1, fb[i], i == 0, with_eof && (i == fb.size() - 1), fe[i], pick_full(full_mode));
    end
  endtask

  task automatic load_frame(input int n, input int start, input bit rnd);
    fb.delete();
    fe.delete();
    for (int i = 0; i < n; i++) begin
      fb.push_back(rnd ? 8'($urandom) : 8'(start + i));
      fe.push_back(1'b0);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_words.size() != 0 || exp_stat.size() != 0) && n < 300) begin
      idle(1'b0);
      n++;
    end
    repeat (2) idle(1'b0);
    check(name, word_t'(exp_words.size() + exp_stat.size()), '0);
  endtask

  // Monitor: every DUT write / status pulse is matched against the next expected entry.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.fifo_write) begin
        if (exp_words.size() == 0) check("write_expected", word_t'(exp_words.size()), word_t'(1));
        else check("fifo_din", bus.fifo_din, exp_words.pop_front());
      end
      if (bus.frame_done) begin
        if (exp_stat.size() == 0) check("status_expected", word_t'(exp_stat.size()), word_t'(1));
        else begin
          mon_s = exp_stat.pop_front();
          check("frame_len", word_t'(bus.frame_len), word_t'(mon_s.len));
          check("frame_bad", word_t'(bus.frame_bad), word_t'(mon_s.bad));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  bit trunc, trunc_prev;
  int nb;

  initial begin
    bus.rx_valid = 0; bus.rx_data = 0; bus.rx_sof = 0; bus.rx_eof = 0;
    bus.rx_err = 0; bus.fifo_full = 0;
    model_reset();
    #12;
    check("rst_fifo_write", word_t'(bus.fifo_write), '0);
    check("rst_frame_done", word_t'(bus.frame_done), '0);
    check("rst_overflow",   word_t'(bus.overflow), '0);
    check("rst_fifo_din",   bus.fifo_din, '0);
    @(posedge clk);
    #1 reset = 1'b1;

    // 1: 64 bytes back-to-back -> two full words
    load_frame(64, 0, 0);
    send_frame(1, 0, 0);
    drain("t1_drain");

    // 2: 33 bytes -> second word carries only 0x20 in lane 0
    load_frame(33, 0, 0);
    send_frame(1, 0, 0);
    drain("t2_drain");

    // 3: FIFO full throughout a 96-byte frame -> first word held, second dropped
    load_frame(96, 8'h40, 0);
    send_frame(1, 0, 1);
    repeat (3) idle(1'b1);
    check("t3_hold_write", word_t'(bus.fifo_write), '0);
    check("t3_hold_din", bus.fifo_din, exp_words[0]);
    check("t3_overflow", word_t'(bus.overflow), word_t'(m_ovf));
    drain("t3_drain");

    // 4: exactly 32 bytes with a gap every other cycle -> single word
    load_frame(32, 8'h80, 0);
    send_frame(1, 1, 0);
    drain("t4_drain");

    // 5: frame A (10 bytes) cut short by the sof of frame B
    load_frame(10, 8'hA0, 0);
    send_frame(0, 0, 0);
    load_frame(6, 8'hB0, 0);
    send_frame(1, 0, 0);
    drain("t5_drain");

    // 6: asynchronous reset mid-frame, then stray bytes, then a clean frame
    load_frame(20, 8'hC0, 0);
    send_frame(0, 0, 0);
    bus.rx_valid = 0; bus.rx_sof = 0; bus.rx_eof = 0; bus.rx_err = 0;
    reset = 1'b0;
    #1;
    check("t6_fifo_write", word_t'(bus.fifo_write), '0);
    check("t6_frame_done", word_t'(bus.frame_done), '0);
    check("t6_frame_len",  word_t'(bus.frame_len), '0);
    check("t6_frame_bad",  word_t'(bus.frame_bad), '0);
    check("t6_overflow",   word_t'(bus.overflow), '0);
    check("t6_fifo_din",   bus.fifo_din, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 5; i++) drive(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'b0, 1'b0);
    load_frame(40, 8'hD0, 0);
    send_frame(1, 0, 0);
    drain("t6_drain");

    // Oversize: 1540 bytes -> 49 words, marked bad
    load_frame(1540, 0, 1);
    send_frame(1, 0, 0);
    drain("big_drain");

    // Random frames: gaps, errors, backpressure, missing eofs, stray bytes
    trunc_prev = 0;
    for (int f = 0; f < 40; f++) begin
      nb = $urandom_range(trunc_prev ? 2 : 1, 80);
      trunc = (f != 39) && ($urandom_range(0, 7) == 0);
      load_frame(nb, 0, 1);
      for (int i = 0; i < nb; i++) fe[i] = ($urandom_range(0, 15) == 0);
      send_frame(!trunc, 2, 2);
      if (!trunc) begin
        repeat ($urandom_range(0, 3)) idle(pick_full(2));
        if ($urandom_range(0, 3) == 0)
          drive(1'b1, 8'($urandom), 1'b0, 1'($urandom), 1'($urandom), 1'b0);
      end
      trunc_prev = trunc;
    end
    drain("rand_drain");
    check("rand_overflow", word_t'(bus.overflow), word_t'(m_ovf));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
